// File: rtl/multi_rate_divider.sv
// -----------------------------------------------------------------------------
// multi_rate_divider
//
// Bank of NUM_CH independent programmable tick generators. Each channel counts
// down from P-1 (P = max(period,1)) and emits a one-cycle Tick when the count
// expires, then reloads. A channel is either periodic (keeps running) or
// one-shot (stops after its first tick). A global Pause freezes all counters.
//
// Ports
//   ClockIn    in   1          clock, all logic on the rising edge
//   Reset      in   1          synchronous, active-high reset
//   CfgWe      in   1          configuration write strobe
//   CfgCh      in   CH_W       channel index for the write
//   CfgPeriod  in   CNT_W      new period in cycles
//   CfgOneShot in   1          new mode: 1 = one-shot, 0 = periodic
//   Start      in   NUM_CH     per-channel start/restart pulse
//   Stop       in   NUM_CH     per-channel stop pulse (wins over Start)
//   Pause      in   1          freeze all counters while high
//   Tick       out  NUM_CH     registered one-cycle tick per channel
//   Running    out  NUM_CH     registered per-channel active flag
// -----------------------------------------------------------------------------
module multi_rate_divider #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 27,
   parameter int DEFAULT_PERIOD = 50000000,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              ClockIn,
   input  logic              Reset,
   input  logic              CfgWe,
   input  logic [CH_W-1:0]   CfgCh,
   input  logic [CNT_W-1:0]  CfgPeriod,
   input  logic              CfgOneShot,
   input  logic [NUM_CH-1:0] Start,
   input  logic [NUM_CH-1:0] Stop,
   input  logic              Pause,
   output logic [NUM_CH-1:0] Tick,
   output logic [NUM_CH-1:0] Running
);

   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] RST_COUNT  =
      CNT_W'((DEFAULT_PERIOD > 1) ? DEFAULT_PERIOD - 1 : 0);

   // Count value loaded on start or reload; a period of 0 behaves as 1.
   function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] p);
      return (p == '0) ? '0 : p - 1'b1;
   endfunction

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] period_q, period_d;
      logic [CNT_W-1:0] counter_q, counter_d;
      logic             oneshot_q, oneshot_d;
      logic             running_q, running_d;
      logic             tick_q, tick_d;
      logic             cfg_hit;

      // An index >= NUM_CH never matches any channel, so such writes drop.
      assign cfg_hit = CfgWe && (CfgCh == CH_W'(c));

      always_comb begin
         // NOTE: every output of this block gets a default first so no path
         // leaves a value unassigned and no latch is inferred.
         period_d  = period_q;
         oneshot_d = oneshot_q;
         counter_d = counter_q;
         running_d = running_q;
         tick_d    = 1'b0;

         if (cfg_hit) begin
            period_d  = CfgPeriod;
            oneshot_d = CfgOneShot;
         end

         if (Stop[c]) begin
            running_d = 1'b0;
         end else if (Start[c]) begin
            // A coincident config write is already visible in period_d.
            counter_d = load_value(period_d);
            running_d = 1'b1;
         end else if (running_q && !Pause) begin
            if (counter_q != '0) begin
               counter_d = counter_q - 1'b1;
            end else begin
               tick_d    = 1'b1;
               counter_d = load_value(period_q);
               running_d = !oneshot_q;
            end
         end
      end

      // NOTE: the per-channel configuration registers are few and small, so
      // they are reset along with the control state rather than left unknown.
      always_ff @(posedge ClockIn) begin
         if (Reset) begin
            period_q  <= RST_PERIOD;
            oneshot_q <= 1'b0;
            counter_q <= RST_COUNT;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments so every register updates from
            // values sampled at the same edge.
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            counter_q <= counter_d;
            running_q <= running_d;
            tick_q    <= tick_d;
         end
      end

      assign Tick[c]    = tick_q;
      assign Running[c] = running_q;
   end

endmodule

// File: tb/tb_multi_rate_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_rate_divider
//
// Self-checking bench for multi_rate_divider (NUM_CH=2, CNT_W=8,
// DEFAULT_PERIOD=5). Each driven cycle pushes the expected Tick/Running pair
// into a scoreboard queue; after the edge the pair is popped and compared.
// Edge k in a scenario is counted from the edge that sampled its Start.
// -----------------------------------------------------------------------------
module tb_multi_rate_divider;

   logic       ClockIn = 1'b0;
   logic       Reset;
   logic       CfgWe;
   logic       CfgCh;
   logic [7:0] CfgPeriod;
   logic       CfgOneShot;
   logic [1:0] Start;
   logic [1:0] Stop;
   logic       Pause;
   logic [1:0] Tick;
   logic [1:0] Running;

   typedef struct packed {
      logic [1:0] tick;
      logic [1:0] run;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   multi_rate_divider #(
      .NUM_CH(2), .CNT_W(8), .DEFAULT_PERIOD(5)
   ) dut (
      .ClockIn   (ClockIn),
      .Reset     (Reset),
      .CfgWe     (CfgWe),
      .CfgCh     (CfgCh),
      .CfgPeriod (CfgPeriod),
      .CfgOneShot(CfgOneShot),
      .Start     (Start),
      .Stop      (Stop),
      .Pause     (Pause),
      .Tick      (Tick),
      .Running   (Running)
   );

   always #5 ClockIn = ~ClockIn;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, push its expectation, clock, then score.
   task automatic cycle(input string tag, input logic rst, input logic [1:0] st,
                        input logic [1:0] sp, input logic pz, input logic we,
                        input logic ch, input logic [7:0] per, input logic os,
                        input logic [1:0] e_tick, input logic [1:0] e_run);
      exp_t e;
      Reset = rst; Start = st; Stop = sp; Pause = pz;
      CfgWe = we; CfgCh = ch; CfgPeriod = per; CfgOneShot = os;
      exp_q.push_back('{tick: e_tick, run: e_run});
      @(posedge ClockIn);
      #1;
      e = exp_q.pop_front();
      check({tag, ".tick"}, {6'd0, Tick}, {6'd0, e.tick});
      check({tag, ".run"},  {6'd0, Running}, {6'd0, e.run});
   endtask

   task automatic idle(input string tag, input logic pz, input logic [1:0] e_tick,
                       input logic [1:0] e_run);
      cycle(tag, 1'b0, 2'b00, 2'b00, pz, 1'b0, 1'b0, 8'd0, 1'b0, e_tick, e_run);
   endtask

   initial begin
      // Reset mid-write: must still leave everything idle.
      cycle("reset", 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 8'd9, 1'b1, 2'b00, 2'b00);
      cycle("reset2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);

      // Periodic ch0 at default period 5; restart coinciding with reload at 20.
      cycle("p0.start", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 25; k++) begin
         logic t;
         t = (k == 5) || (k == 10) || (k == 15) || (k == 25);
         cycle($sformatf("p0.e%0d", k), 1'b0, (k == 20) ? 2'b01 : 2'b00, 2'b00,
               1'b0, 1'b0, 1'b0, 8'd0, 1'b0, {1'b0, t}, 2'b01);
      end
      cycle("p0.stop", 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);

      // One-shot ch1, period 3.
      cycle("os.cfg", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 2'b00, 2'b00);
      cycle("os.start", 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b10);
      idle("os.e1", 1'b0, 2'b00, 2'b10);
      idle("os.e2", 1'b0, 2'b00, 2'b10);
      idle("os.e3", 1'b0, 2'b10, 2'b00);
      for (int k = 4; k <= 23; k++) idle($sformatf("os.e%0d", k), 1'b0, 2'b00, 2'b00);

      // Pause for 4 edges mid-count: ticks at 5, then 14 and 19 instead of 10, 15.
      cycle("pz.start", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 20; k++) begin
         logic pz;
         logic t;
         pz = (k >= 8) && (k <= 11);
         t  = !pz && (((k > 11) ? k - 4 : k) % 5 == 0);
         idle($sformatf("pz.e%0d", k), pz, {1'b0, t}, 2'b01);
      end

      // Start and Stop together: Stop wins.
      cycle("ss.both", 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);
      for (int k = 1; k <= 8; k++) idle($sformatf("ss.e%0d", k), 1'b0, 2'b00, 2'b00);
      cycle("ss.start", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 5; k++)
         idle($sformatf("ss.s%0d", k), 1'b0, {1'b0, k == 5}, 2'b01);

      // Period 0 written together with Start: tick every cycle.
      cycle("z.start", 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 6; k++) idle($sformatf("z.e%0d", k), 1'b0, 2'b01, 2'b01);
      cycle("z.stop", 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);

      // Period 7 on ch0, reset two edges before the tick due at edge 7.
      cycle("r.start", 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 8'd7, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 4; k++) idle($sformatf("r.e%0d", k), 1'b0, 2'b00, 2'b01);
      cycle("r.rst5", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);
      cycle("r.rst6", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00);
      idle("r.e7", 1'b0, 2'b00, 2'b00);
      cycle("r.restart", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b01);
      for (int k = 1; k <= 6; k++)
         idle($sformatf("r.s%0d", k), 1'b0, {1'b0, k == 5}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
